// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; 33-cycle latency for WIDTH=32.
// Core stalls on busy_o; `define DIV_FAST_SPECIAL_EN finishes divide-by-zero/overflow in one cycle.
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_div_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_abs;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [CNT_W-1:0]   cnt;
    logic               sign_a, sign_b, div_zero, ovf;

    logic               is_signed_in, sa_in, sb_in, zero_in, ovf_in, fast_in;
    logic               accept, load_res, last_step;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_step, quo_step, quo_fix, rem_fix, res_calc, res_fast;

    function automatic logic [WIDTH-1:0] special_val(input logic want_rem, input logic zero,
                                                     input logic [WIDTH-1:0] dvd);
        if (zero)
            return want_rem ? dvd : '1;
        // Signed overflow: -2^(W-1) / -1
        return want_rem ? '0 : dvd;
    endfunction

    always_comb begin
        is_signed_in = ~op_div_i[0];
        sa_in        = is_signed_in & dividend_i[WIDTH-1];
        sb_in        = is_signed_in & divisor_i[WIDTH-1];
        zero_in      = (divisor_i == '0);
        ovf_in       = is_signed_in && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
`ifdef DIV_FAST_SPECIAL_EN
        fast_in      = zero_in | ovf_in;
`else
        fast_in      = 1'b0;
`endif
        accept       = (state == IDLE) && start_i && !kill_i;
        res_fast     = special_val(op_div_i[1], zero_in, dividend_i);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, dvs_abs});
        rem_step = ge ? WIDTH'(rem_sh - {1'b0, dvs_abs}) : rem_sh[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], ge};
        quo_fix  = (sign_a ^ sign_b) ? -quo_step : quo_step;
        rem_fix  = sign_a ? -rem_step : rem_step;
        if (div_zero || ovf)
            res_calc = special_val(op_q[1], div_zero, dvd_q);
        else
            res_calc = op_q[1] ? rem_fix : quo_fix;
    end

    always_comb begin
        state_nxt = state;
        last_step = (state == CALC) && !kill_i && (cnt == '0);
        load_res  = last_step || (accept && fast_in);
        case (state)
            IDLE: if (accept) state_nxt = fast_in ? DONE : CALC;
            CALC: if (kill_i) state_nxt = IDLE;
                  else if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q     <= '0;
            dvd_q    <= '0;
            dvs_abs  <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            result_o <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_div_i;
                dvd_q    <= dividend_i;
                quo      <= sa_in ? -dividend_i : dividend_i;
                dvs_abs  <= sb_in ? -divisor_i : divisor_i;
                rem      <= '0;
                cnt      <= CNT_W'(WIDTH - 1);
                sign_a   <= sa_in;
                sign_b   <= sb_in;
                div_zero <= zero_in;
                ovf      <= ovf_in;
            end else if (state == CALC) begin
                quo <= quo_step;
                rem <= rem_step;
                cnt <= cnt - 1'b1;
            end
            if (load_res)
                result_o <= accept ? res_fast : res_calc;
        end
    end

    assign busy_o = (state == CALC);
    assign done_o = (state == DONE);

endmodule
